// File: rtl/rv32i_imem_loader_ctrl_pkg.sv
// Shared definitions for the instruction-memory loader controller:
// memory geometry defaults, the fetch NOP encoding and the controller FSM states.
package rv32i_imem_loader_ctrl_pkg;

  localparam int          INSTR_MEM_WIDTH = 10;
  localparam int          INSTR_MEM_DEPTH = 1024;
  localparam logic [31:0] NOP_ENCODING    = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic [1:0] {
    ST_HOLD  = 2'd0,
    ST_RUN   = 2'd1,
    ST_LOAD  = 2'd2,
    ST_WRITE = 2'd3
  } ld_state_e;

endpackage

// File: rtl/rv32i_imem_loader_ctrl.sv
// Instruction memory controller: core fetch path plus a byte-stream program loader
// that packs bytes little-endian into words and holds the core while loading.
module rv32i_imem_loader_ctrl
  import rv32i_imem_loader_ctrl_pkg::*;
#(
  parameter int          AW        = INSTR_MEM_WIDTH,
  parameter int          DEPTH     = INSTR_MEM_DEPTH,
  parameter bit          BOOT_HOLD = 1'b1,
  parameter logic [31:0] NOP_INSTR = NOP_ENCODING
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ld_start,
  input  logic [AW-1:0] ld_base,
  input  logic [AW:0]   ld_words,
  input  logic          ld_valid,
  input  logic [7:0]    ld_data,
  output logic          ld_ready,
  output logic          ld_busy,
  output logic          ld_err,
  output logic          core_hold,
  input  logic [31:0]   fetch_addr,
  output logic [31:0]   fetch_instr,
  output logic [AW-1:0] mem_raddr,
  input  logic [31:0]   mem_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_waddr,
  output logic [31:0]   mem_wdata
);

  localparam logic [AW+1:0] DEPTH_W = (AW+2)'(DEPTH);

  ld_state_e     state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW:0]   remain_q, remain_d;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [31:0]   word_q, word_d;
  logic          ld_err_q, ld_err_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_waddr_q, mem_waddr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic          ld_ready_q, ld_busy_q, core_hold_q;
  logic [AW+1:0] end_idx;
  logic          unused_fetch_bits;

  // Range check is one bit wider than the sum so base+words never aliases.
  assign end_idx = {2'b00, ld_base} + {1'b0, ld_words};

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    remain_d    = remain_q;
    byte_cnt_d  = byte_cnt_q;
    word_d      = word_q;
    ld_err_d    = ld_err_q;
    mem_we_d    = 1'b0;
    mem_waddr_d = mem_waddr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      ST_HOLD, ST_RUN: begin
        if (ld_start) begin
          if (ld_words == '0 || end_idx > DEPTH_W) begin
            ld_err_d = 1'b1;
          end else begin
            ptr_d      = ld_base;
            remain_d   = ld_words;
            byte_cnt_d = 2'd0;
            ld_err_d   = 1'b0;
            state_d    = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (ld_start) ld_err_d = 1'b1;
        if (ld_valid && ld_ready_q) begin
          word_d[{byte_cnt_q, 3'b000} +: 8] = ld_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            mem_we_d    = 1'b1;
            mem_waddr_d = ptr_q;
            mem_wdata_d = {ld_data, word_q[23:0]};
            state_d     = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        if (ld_start) ld_err_d = 1'b1;
        ptr_d    = ptr_q + 1'b1;
        remain_d = remain_q - 1'b1;
        state_d  = (remain_q == (AW+1)'(1)) ? ST_RUN : ST_LOAD;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= BOOT_HOLD ? ST_HOLD : ST_RUN;
      ptr_q       <= '0;
      remain_q    <= '0;
      byte_cnt_q  <= 2'd0;
      word_q      <= '0;
      ld_err_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_waddr_q <= '0;
      mem_wdata_q <= '0;
      ld_ready_q  <= 1'b0;
      ld_busy_q   <= 1'b0;
      core_hold_q <= BOOT_HOLD;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      remain_q    <= remain_d;
      byte_cnt_q  <= byte_cnt_d;
      word_q      <= word_d;
      ld_err_q    <= ld_err_d;
      mem_we_q    <= mem_we_d;
      mem_waddr_q <= mem_waddr_d;
      mem_wdata_q <= mem_wdata_d;
      // Handshake/status flags follow the state being entered so they are registered.
      ld_ready_q  <= (state_d == ST_LOAD);
      ld_busy_q   <= (state_d == ST_LOAD) || (state_d == ST_WRITE);
      core_hold_q <= (state_d != ST_RUN);
    end
  end

  assign ld_ready  = ld_ready_q;
  assign ld_busy   = ld_busy_q;
  assign ld_err    = ld_err_q;
  assign core_hold = core_hold_q;
  assign mem_we    = mem_we_q;
  assign mem_waddr = mem_waddr_q;
  assign mem_wdata = mem_wdata_q;

  assign mem_raddr   = fetch_addr[AW+1:2];
  assign fetch_instr = core_hold_q ? NOP_INSTR : mem_rdata;

  assign unused_fetch_bits = ^{fetch_addr[31:AW+2], fetch_addr[1:0]};

endmodule

// File: tb/tb_rv32i_imem_loader_ctrl.sv
// Scoreboarded bench for the imem loader: expected writes are queued as bytes are
// driven and popped as mem_we pulses appear; status/fetch outputs checked directly.
module tb_rv32i_imem_loader_ctrl;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ld_start;
  logic [AW-1:0] ld_base;
  logic [AW:0]   ld_words;
  logic          ld_valid;
  logic [7:0]    ld_data;
  logic          ld_ready, ld_busy, ld_err, core_hold;
  logic [31:0]   fetch_addr, fetch_instr, mem_rdata;
  logic [AW-1:0] mem_raddr, mem_waddr;
  logic          mem_we;
  logic [31:0]   mem_wdata;

  logic [31:0]   tbmem [DEPTH];
  logic [AW+31:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rv32i_imem_loader_ctrl #(.AW(AW), .DEPTH(DEPTH), .BOOT_HOLD(1'b1), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .ld_start(ld_start), .ld_base(ld_base), .ld_words(ld_words),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready), .ld_busy(ld_busy),
    .ld_err(ld_err), .core_hold(core_hold), .fetch_addr(fetch_addr),
    .fetch_instr(fetch_instr), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
  );

  always @(posedge clk) if (mem_we) tbmem[mem_waddr] <= mem_wdata;
  assign mem_rdata = tbmem[mem_raddr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h @%0t", tag, obs, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_we", 32'(mem_waddr), 32'hFFFF_FFFF);
      end else begin
        logic [AW+31:0] e;
        e = exp_q.pop_front();
        chk("waddr", 32'(mem_waddr), 32'(e[AW+31:32]));
        chk("wdata", mem_wdata, e[31:0]);
      end
    end
  end

  task automatic start_load(input logic [AW-1:0] base, input logic [AW:0] words);
    ld_start = 1'b1;
    ld_base  = base;
    ld_words = words;
    @(negedge clk);
    ld_start = 1'b0;
  endtask

  // Byte is taken at the posedge following a negedge where ready is seen.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int tmo = 0;
    ld_valid = 1'b1;
    ld_data  = b;
    while (!ld_ready && tmo < 50) begin
      @(negedge clk);
      tmo++;
    end
    if (!ld_ready) begin
      chk("ready_timeout", 32'(ld_ready), 32'd1);
      ld_valid = 1'b0;
    end else begin
      @(negedge clk);
      ld_valid = 1'b0;
      if (gap) @(negedge clk);
    end
  endtask

  task automatic load_word(input logic [AW-1:0] addr, input logic [31:0] w, input bit gap);
    exp_q.push_back({addr, w});
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) tbmem[i] = 32'hDEAD_0000 | 32'(i);
    rst_n = 1'b0; ld_start = 0; ld_base = '0; ld_words = '0;
    ld_valid = 0; ld_data = '0; fetch_addr = 32'h0;
    repeat (3) @(negedge clk);

    // 1: reset / boot hold
    chk("rst_hold", 32'(core_hold), 32'd1);
    chk("rst_ready", 32'(ld_ready), 32'd0);
    chk("rst_busy", 32'(ld_busy), 32'd0);
    chk("rst_err", 32'(ld_err), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_nop0", fetch_instr, NOP);
    rst_n = 1'b1;
    @(negedge clk);
    fetch_addr = 32'h8; #1;
    chk("boot_nop2", fetch_instr, NOP);
    chk("boot_hold", 32'(core_hold), 32'd1);

    // 2: two-word load from base 0
    @(negedge clk);
    start_load(4'd0, 5'd2);
    chk("load_busy", 32'(ld_busy), 32'd1);
    chk("load_ready", 32'(ld_ready), 32'd1);
    load_word(4'd0, 32'h0010_0513, 1'b0);
    load_word(4'd1, 32'h0020_0593, 1'b0);
    chk("last_we", 32'(mem_we), 32'd1);
    chk("hold_in_write", 32'(core_hold), 32'd1);
    chk("ready_in_write", 32'(ld_ready), 32'd0);
    @(negedge clk);
    chk("hold_released", 32'(core_hold), 32'd0);
    chk("busy_released", 32'(ld_busy), 32'd0);
    fetch_addr = 32'h0000_0007; #1;
    chk("fetch_w1", fetch_instr, 32'h0020_0593);
    fetch_addr = 32'h0000_0002; #1;
    chk("fetch_w0", fetch_instr, 32'h0010_0513);

    // 3: same words with ld_valid toggling each cycle
    @(negedge clk);
    start_load(4'd2, 5'd2);
    load_word(4'd2, 32'h0010_0513, 1'b1);
    load_word(4'd3, 32'h0020_0593, 1'b1);
    repeat (2) @(negedge clk);
    fetch_addr = 32'h0000_000C; #1;
    chk("fetch_w3", fetch_instr, 32'h0020_0593);

    // 4: range error from RUN
    @(negedge clk);
    start_load(4'(DEPTH-1), 5'd2);
    chk("range_err", 32'(ld_err), 32'd1);
    chk("range_hold", 32'(core_hold), 32'd0);
    chk("range_busy", 32'(ld_busy), 32'd0);
    repeat (3) @(negedge clk);
    chk("range_ready", 32'(ld_ready), 32'd0);

    // 5: ld_start during a load
    start_load(4'd8, 5'd1);
    chk("err_cleared", 32'(ld_err), 32'd0);
    exp_q.push_back({4'd8, 32'hCAFE_BABE});
    send_byte(8'hBE, 1'b0);
    send_byte(8'hBA, 1'b0);
    start_load(4'd0, 5'd1);
    chk("midload_err", 32'(ld_err), 32'd1);
    chk("midload_busy", 32'(ld_busy), 32'd1);
    send_byte(8'hFE, 1'b0);
    send_byte(8'hCA, 1'b0);
    repeat (2) @(negedge clk);
    chk("after_mid_busy", 32'(ld_busy), 32'd0);
    fetch_addr = 32'h0000_0020; #1;
    chk("fetch_w8", fetch_instr, 32'hCAFE_BABE);

    // 6: reset after 2 bytes of a word
    @(negedge clk);
    start_load(4'd10, 5'd1);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    rst_n = 1'b0; #1;
    chk("mid_rst_hold", 32'(core_hold), 32'd1);
    chk("mid_rst_ready", 32'(ld_ready), 32'd0);
    chk("mid_rst_busy", 32'(ld_busy), 32'd0);
    chk("mid_rst_err", 32'(ld_err), 32'd0);
    chk("mid_rst_waddr", 32'(mem_waddr), 32'd0);
    chk("mid_rst_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    fetch_addr = 32'h0000_0028; #1;
    chk("after_rst_nop", fetch_instr, NOP);

    // Zero-length load rejected in HOLD, then last-word boundary load accepted
    start_load(4'd0, 5'd0);
    chk("zero_err", 32'(ld_err), 32'd1);
    chk("zero_hold", 32'(core_hold), 32'd1);
    start_load(4'(DEPTH-1), 5'd1);
    chk("edge_err_clr", 32'(ld_err), 32'd0);
    load_word(4'(DEPTH-1), 32'h1234_5678, 1'b0);
    @(negedge clk);
    chk("edge_hold", 32'(core_hold), 32'd0);
    fetch_addr = 32'h0000_003C; #1;
    chk("fetch_last", fetch_instr, 32'h1234_5678);
    chk("word10_intact", tbmem[10], 32'hDEAD_000A);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
